// File: rtl/facto_host_if.sv
// Bus between facto_host and the shared memory / FactoCore fabric.
//
// Handshake: m_req is held high for the whole batch. An access (address,
// write strobe and write data) completes on a rising edge where the host
// presents it and m_grant=1. With m_grant=0 the host holds everything unchanged.
// Read data appears on m_din in the cycle after the address phase.
interface facto_host_if;
    logic        m_req;
    logic        m_wr;
    logic [15:0] m_addr;
    logic [63:0] m_dout;
    logic        m_grant;
    logic [63:0] m_din;

    modport master (
        output m_req, m_wr, m_addr, m_dout,
        input  m_grant, m_din
    );

    modport slave (
        input  m_req, m_wr, m_addr, m_dout,
        output m_grant, m_din
    );
endinterface

// File: rtl/facto_host.sv
// facto_host: walks a list of 64-bit operands in memory, runs each one through
// the memory-mapped FactoCore and writes the 128-bit result (high word, then
// low word) to a result list. The bus transaction sequence is driven by a
// single FSM whose state is exported on dbg_state.
module facto_host #(
    parameter logic [15:0] FACTO_BASE = 16'h7000,
    parameter logic [15:0] MEM_TOP    = 16'h07FF
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [15:0]  src_addr,
    input  logic [15:0]  dst_addr,
    input  logic [7:0]   count,
    input  logic         interrupt,
    facto_host_if.master bus,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [4:0]   dbg_state
);

    localparam logic [15:0] OFF_OPSTART  = 16'h0000;
    localparam logic [15:0] OFF_OPCLEAR  = 16'h0008;
    localparam logic [15:0] OFF_INTREN   = 16'h0018;
    localparam logic [15:0] OFF_OPERAND  = 16'h0020;
    localparam logic [15:0] OFF_RESULT_H = 16'h0028;
    localparam logic [15:0] OFF_RESULT_L = 16'h0030;
    localparam logic [63:0] CMD_ONE      = 64'd1;

    typedef enum logic [4:0] {
        IDLE, REQ, RD_OP_A, RD_OP_D, WR_OPND, WR_IEN, WR_GO, WAIT_INT,
        RD_H_A, RD_H_D, RD_L_A, RD_L_D, WR_RH, WR_RL, WR_CLR, NEXT, FIN
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] src_q, dst_q;
    logic [7:0]  cnt_q, idx_q;
    logic [63:0] opnd_q, res_h_q, res_l_q;
    logic [15:0] addr_q;
    logic [63:0] dout_q;
    logic        err_q;

    // Current access as seen on the bus; outside access states these fall
    // back to the held registers so m_addr/m_dout keep their last value.
    logic        is_access;
    logic        acc_wr;
    logic [15:0] acc_addr;
    logic [63:0] acc_wdata;

    logic [15:0] op_addr, res_addr;
    logic [17:0] src_end, dst_end;
    logic        range_bad;
    logic        last_op;

    assign op_addr  = src_q + {5'b0, idx_q, 3'b0};
    assign res_addr = dst_q + {4'b0, idx_q, 4'b0};
    assign last_op  = ((idx_q + 8'd1) == cnt_q);

    // Last byte touched by the operand and result lists, checked at acceptance.
    assign src_end   = {2'b00, src_addr[15:3], 3'b000} + {7'b0, count, 3'b000} - 18'd1;
    assign dst_end   = {2'b00, dst_addr[15:3], 3'b000} + {6'b0, count, 4'b0000} - 18'd1;
    assign range_bad = (src_end > {2'b00, MEM_TOP}) || (dst_end > {2'b00, MEM_TOP});

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic: access states advance only on a granted cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (count == 8'd0 || range_bad) state_d = FIN;
                    else                            state_d = REQ;
                end
            end
            REQ:      if (bus.m_grant) state_d = RD_OP_A;
            RD_OP_A:  if (bus.m_grant) state_d = RD_OP_D;
            RD_OP_D:  state_d = WR_OPND;
            WR_OPND:  if (bus.m_grant) state_d = WR_IEN;
            WR_IEN:   if (bus.m_grant) state_d = WR_GO;
            WR_GO:    if (bus.m_grant) state_d = WAIT_INT;
            WAIT_INT: if (interrupt)   state_d = RD_H_A;
            RD_H_A:   if (bus.m_grant) state_d = RD_H_D;
            RD_H_D:   state_d = RD_L_A;
            RD_L_A:   if (bus.m_grant) state_d = RD_L_D;
            RD_L_D:   state_d = WR_RH;
            WR_RH:    if (bus.m_grant) state_d = WR_RL;
            WR_RL:    if (bus.m_grant) state_d = WR_CLR;
            WR_CLR:   if (bus.m_grant) state_d = NEXT;
            NEXT:     state_d = last_op ? FIN : RD_OP_A;
            FIN:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Per-state bus access decode.
    always_comb begin
        is_access = 1'b0;
        acc_wr    = 1'b0;
        acc_addr  = addr_q;
        acc_wdata = dout_q;
        case (state_q)
            RD_OP_A: begin
                is_access = 1'b1;
                acc_addr  = op_addr;
            end
            WR_OPND: begin
                is_access = 1'b1;
                acc_wr    = 1'b1;
                acc_addr  = FACTO_BASE + OFF_OPERAND;
                acc_wdata = opnd_q;
            end
            WR_IEN: begin
                is_access = 1'b1;
                acc_wr    = 1'b1;
                acc_addr  = FACTO_BASE + OFF_INTREN;
                acc_wdata = CMD_ONE;
            end
            WR_GO: begin
                is_access = 1'b1;
                acc_wr    = 1'b1;
                acc_addr  = FACTO_BASE + OFF_OPSTART;
                acc_wdata = CMD_ONE;
            end
            RD_H_A: begin
                is_access = 1'b1;
                acc_addr  = FACTO_BASE + OFF_RESULT_H;
            end
            RD_L_A: begin
                is_access = 1'b1;
                acc_addr  = FACTO_BASE + OFF_RESULT_L;
            end
            WR_RH: begin
                is_access = 1'b1;
                acc_wr    = 1'b1;
                acc_addr  = res_addr;
                acc_wdata = res_h_q;
            end
            WR_RL: begin
                is_access = 1'b1;
                acc_wr    = 1'b1;
                acc_addr  = res_addr + 16'd8;
                acc_wdata = res_l_q;
            end
            WR_CLR: begin
                is_access = 1'b1;
                acc_wr    = 1'b1;
                acc_addr  = FACTO_BASE + OFF_OPCLEAR;
                acc_wdata = CMD_ONE;
            end
            default: ;
        endcase
    end

    // Batch context, captured read data and held bus values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            opnd_q  <= '0;
            res_h_q <= '0;
            res_l_q <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state_q == IDLE && start) begin
                src_q <= {src_addr[15:3], 3'b000};
                dst_q <= {dst_addr[15:3], 3'b000};
                cnt_q <= count;
                idx_q <= '0;
                err_q <= (count != 8'd0) && range_bad;
            end
            if (is_access) begin
                addr_q <= acc_addr;
                if (acc_wr) dout_q <= acc_wdata;
            end
            if (state_q == RD_OP_D) opnd_q  <= bus.m_din;
            if (state_q == RD_H_D)  res_h_q <= bus.m_din;
            if (state_q == RD_L_D)  res_l_q <= bus.m_din;
            if (state_q == NEXT)    idx_q   <= idx_q + 8'd1;
        end
    end

    assign bus.m_req  = (state_q != IDLE) && (state_q != FIN);
    assign bus.m_wr   = acc_wr;
    assign bus.m_addr = acc_addr;
    assign bus.m_dout = acc_wdata;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == FIN);
    assign err        = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_facto_host.sv
// Directed bench for facto_host: a memory + FactoCore bus model, per-batch
// driver task with optional in-flight disturbances, and hand-computed results.
`timescale 1ns/1ps
module tb_facto_host;

    localparam logic [4:0] S_IDLE     = 5'd0;
    localparam logic [4:0] S_WR_IEN   = 5'd5;
    localparam logic [4:0] S_WR_GO    = 5'd6;
    localparam logic [4:0] S_WAIT_INT = 5'd7;

    localparam int M_PLAIN   = 0;
    localparam int M_STALL   = 1;
    localparam int M_RESET   = 2;
    localparam int M_RESTART = 3;
    localparam int M_SPUR    = 4;
    localparam int INT_DELAY = 3;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] src_addr, dst_addr;
    logic [7:0]  count;
    logic        interrupt;
    logic        busy, done, err;
    logic [4:0]  dbg_state;

    facto_host_if bus ();

    facto_host dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .count     (count),
        .interrupt (interrupt),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- memory + FactoCore model ----------------
    logic [63:0]  mem [0:255];
    logic [63:0]  core_opnd;
    logic         core_ien;
    logic [127:0] core_res;
    logic         core_int;
    logic         spur;
    int           int_ctr      = 0;
    int           opstart_cnt  = 0;
    int           opclear_cnt  = 0;
    int           bad_cmd_cnt  = 0;
    int           done_cnt     = 0;
    int           req_cyc      = 0;
    logic         pre_en;
    logic [7:0]   pre_idx;
    logic [63:0]  pre_val;

    assign interrupt = core_int | spur;

    function automatic logic [127:0] fact(input logic [63:0] n);
        logic [127:0] r;
        r = 128'd1;
        for (int i = 2; i <= int'(n); i++) r = r * 128'(i);
        return r;
    endfunction

    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_val;
        if (!reset_n) begin
            core_int <= 1'b0;
            int_ctr  <= 0;
            core_ien <= 1'b0;
        end else begin
            if (int_ctr == 1) begin
                core_int <= 1'b1;
                int_ctr  <= 0;
            end else if (int_ctr > 1) begin
                int_ctr <= int_ctr - 1;
            end
            if (bus.m_req && bus.m_grant) begin
                if (bus.m_wr) begin
                    if (bus.m_addr <= 16'h07FF) begin
                        mem[bus.m_addr[10:3]] <= bus.m_dout;
                    end else begin
                        case (bus.m_addr)
                            16'h7020: core_opnd <= bus.m_dout;
                            16'h7018: begin
                                core_ien <= bus.m_dout[0];
                                if (bus.m_dout != 64'd1) bad_cmd_cnt <= bad_cmd_cnt + 1;
                            end
                            16'h7000: begin
                                core_res    <= fact(core_opnd);
                                opstart_cnt <= opstart_cnt + 1;
                                if (core_ien) int_ctr <= INT_DELAY;
                                if (bus.m_dout != 64'd1) bad_cmd_cnt <= bad_cmd_cnt + 1;
                            end
                            16'h7008: begin
                                core_int    <= 1'b0;
                                opclear_cnt <= opclear_cnt + 1;
                                if (bus.m_dout != 64'd1) bad_cmd_cnt <= bad_cmd_cnt + 1;
                            end
                            default: bad_cmd_cnt <= bad_cmd_cnt + 1;
                        endcase
                    end
                end else begin
                    if (bus.m_addr <= 16'h07FF)      bus.m_din <= mem[bus.m_addr[10:3]];
                    else if (bus.m_addr == 16'h7028) bus.m_din <= core_res[127:64];
                    else if (bus.m_addr == 16'h7030) bus.m_din <= core_res[63:0];
                    else                             bus.m_din <= 64'd0;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (done)        done_cnt <= done_cnt + 1;
        if (bus.m_req)   req_cyc  <= req_cyc + 1;
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic load(input logic [7:0] idx, input logic [63:0] val);
        @(negedge clk);
        pre_idx = idx;
        pre_val = val;
        pre_en  = 1'b1;
        @(negedge clk);
        pre_en  = 1'b0;
    endtask

    // Launches one batch and follows it to done (or to the reset hook).
    task automatic run_batch(input logic [15:0] s, input logic [15:0] d, input logic [7:0] n,
                             input int mode, output int busy_low, output int lat);
        logic done_seen, aborted, hooked;
        done_seen = 1'b0;
        aborted   = 1'b0;
        hooked    = 1'b0;
        busy_low  = 0;
        lat       = -1;
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        count    = n;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (done) begin
                done_seen = 1'b1;
                lat       = cyc;
                break;
            end
            if (!busy) busy_low++;
            if (!hooked) begin
                if (mode == M_STALL && dbg_state == S_WR_GO) begin
                    hooked = 1'b1;
                    bus.m_grant = 1'b0;
                    for (int k = 0; k < 5; k++) begin
                        @(negedge clk);
                        check("stall_addr", bus.m_addr, 64'h7000);
                        check("stall_wr", bus.m_wr, 1);
                        check("stall_dout", bus.m_dout, 1);
                    end
                    bus.m_grant = 1'b1;
                end else if (mode == M_RESET && dbg_state == S_WAIT_INT) begin
                    reset_n = 1'b0;
                    #1;
                    check("rst_m_req", bus.m_req, 0);
                    check("rst_m_wr", bus.m_wr, 0);
                    check("rst_m_addr", bus.m_addr, 0);
                    check("rst_m_dout", bus.m_dout, 0);
                    check("rst_busy", busy, 0);
                    check("rst_done", done, 0);
                    check("rst_err", err, 0);
                    check("rst_state", dbg_state, S_IDLE);
                    @(negedge clk);
                    reset_n = 1'b1;
                    aborted = 1'b1;
                    break;
                end else if (mode == M_RESTART && dbg_state == S_WAIT_INT) begin
                    hooked   = 1'b1;
                    src_addr = 16'h0100;
                    dst_addr = 16'h0000;
                    count    = 8'd7;
                    start    = 1'b1;
                    @(negedge clk);
                    start    = 1'b0;
                end else if (mode == M_SPUR && dbg_state == S_WR_IEN) begin
                    hooked = 1'b1;
                    spur   = 1'b1;
                    @(negedge clk);
                    spur   = 1'b0;
                end
            end
            @(negedge clk);
        end
        if (!aborted) check("batch_done", done_seen, 1);
    endtask

    // ---------------- directed sequence ----------------
    int bl, lat, d0, c0, s0, r0;

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        src_addr    = '0;
        dst_addr    = '0;
        count       = '0;
        spur        = 1'b0;
        pre_en      = 1'b0;
        pre_idx     = '0;
        pre_val     = '0;
        bus.m_grant = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_m_req", bus.m_req, 0);
        check("reset_m_wr", bus.m_wr, 0);
        check("reset_m_addr", bus.m_addr, 0);
        check("reset_m_dout", bus.m_dout, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        check("reset_state", dbg_state, S_IDLE);
        reset_n = 1'b1;

        // Single operand 5 -> 5! = 120
        load(8'h00, 64'd5);
        d0 = done_cnt; c0 = opclear_cnt;
        run_batch(16'h0000, 16'h0100, 8'd1, M_PLAIN, bl, lat);
        check("single_busy_low", bl, 0);
        @(negedge clk);
        check("single_res_h", mem[8'h20], 64'd0);
        check("single_res_l", mem[8'h21], 64'd120);
        check("single_done_cnt", done_cnt - d0, 1);
        check("single_opclear", opclear_cnt - c0, 1);
        check("single_busy_after", busy, 0);
        check("single_done_after", done, 0);

        // Batch of four: 0!,1!,3!,10!
        load(8'h00, 64'd0);
        load(8'h01, 64'd1);
        load(8'h02, 64'd3);
        load(8'h03, 64'd10);
        d0 = done_cnt; c0 = opclear_cnt;
        run_batch(16'h0000, 16'h0100, 8'd4, M_PLAIN, bl, lat);
        check("batch_busy_low", bl, 0);
        @(negedge clk);
        check("batch_res_l0", mem[8'h21], 64'd1);
        check("batch_res_l1", mem[8'h23], 64'd1);
        check("batch_res_l2", mem[8'h25], 64'd6);
        check("batch_res_l3", mem[8'h27], 64'd3628800);
        check("batch_res_h3", mem[8'h26], 64'd0);
        check("batch_done_cnt", done_cnt - d0, 1);
        check("batch_opclear", opclear_cnt - c0, 4);

        // Grant stall in WR_GO: 4! = 24, opstart written exactly once
        load(8'h00, 64'd4);
        s0 = opstart_cnt; c0 = opclear_cnt;
        run_batch(16'h0000, 16'h0200, 8'd1, M_STALL, bl, lat);
        @(negedge clk);
        check("stall_res_h", mem[8'h40], 64'd0);
        check("stall_res_l", mem[8'h41], 64'd24);
        check("stall_opstart", opstart_cnt - s0, 1);
        check("stall_opclear", opclear_cnt - c0, 1);

        // count = 0: done the cycle after start, never requests the bus
        d0 = done_cnt; r0 = req_cyc;
        run_batch(16'h0000, 16'h0100, 8'd0, M_PLAIN, bl, lat);
        check("zero_latency", lat, 0);
        check("zero_err", err, 0);
        @(negedge clk);
        check("zero_req_cycles", req_cyc - r0, 0);
        check("zero_done_cnt", done_cnt - d0, 1);
        check("zero_busy_after", busy, 0);

        // Result list runs past MEM_TOP: err, no bus activity
        d0 = done_cnt; r0 = req_cyc;
        run_batch(16'h0000, 16'h07F8, 8'd1, M_PLAIN, bl, lat);
        check("range_latency", lat, 0);
        check("range_err", err, 1);
        repeat (4) @(negedge clk);
        check("range_req_cycles", req_cyc - r0, 0);
        check("range_done_cnt", done_cnt - d0, 1);
        check("range_err_sticky", err, 1);

        // Start pulsed in WAIT_INT is ignored; low address bits ignored; err cleared
        load(8'h00, 64'd6);
        d0 = done_cnt; c0 = opclear_cnt;
        run_batch(16'h0003, 16'h0407, 8'd1, M_RESTART, bl, lat);
        check("restart_err_cleared", err, 0);
        repeat (30) @(negedge clk);
        check("restart_done_cnt", done_cnt - d0, 1);
        check("restart_opclear", opclear_cnt - c0, 1);
        check("restart_res_l", mem[8'h81], 64'd720);
        check("restart_busy_after", busy, 0);

        // Reset during WAIT_INT abandons the batch without opclear
        load(8'h00, 64'd5);
        c0 = opclear_cnt;
        run_batch(16'h0000, 16'h0300, 8'd1, M_RESET, bl, lat);
        repeat (2) @(negedge clk);
        check("rst_opclear", opclear_cnt - c0, 0);
        c0 = opclear_cnt; d0 = done_cnt;
        run_batch(16'h0000, 16'h0300, 8'd1, M_PLAIN, bl, lat);
        @(negedge clk);
        check("rerun_res_l", mem[8'h61], 64'd120);
        check("rerun_opclear", opclear_cnt - c0, 1);
        check("rerun_done_cnt", done_cnt - d0, 1);

        // Spurious interrupt mid-batch and in IDLE
        load(8'h00, 64'd3);
        run_batch(16'h0000, 16'h0500, 8'd1, M_SPUR, bl, lat);
        @(negedge clk);
        check("spur_res_l", mem[8'hA1], 64'd6);
        d0 = done_cnt;
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        @(negedge clk);
        check("spur_idle_state", dbg_state, S_IDLE);
        check("spur_idle_busy", busy, 0);
        check("spur_idle_done_cnt", done_cnt - d0, 0);

        check("cmd_data", bad_cmd_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/facto_host.md
FACTO_HOST -- requirements
Module: facto_host

Interface
REQ-001 Parameters SHALL be: FACTO_BASE, 16'h7000, FactoCore register base; MEM_TOP, 16'h07FF, highest legal memory byte address.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  one-cycle request to begin a batch; sampled only in IDLE.
REQ-005 src_addr, dst_addr  input  16 each  byte addresses of the operand list and result list; bits [2:0] ignored (treated as 0).
REQ-006 count  input  8  number of operands in the batch.
REQ-007 m_grant  input  1  bus grant.
REQ-008 m_din  input  64  bus read data.
REQ-009 interrupt  input  1  FactoCore completion interrupt.
REQ-010 m_req, m_wr  output  1 each  bus request and write strobe.
REQ-011 m_addr  output  16  bus address.
REQ-012 m_dout  output  64  bus write data.
REQ-013 busy  output  1  high from batch acceptance until done.
REQ-014 done  output  1  one-cycle pulse at batch end.
REQ-015 err  output  1  sticky; set on an address-range violation, cleared by the next accepted start.

Function
REQ-016 FactoCore register offsets SHALL be: opstart +0x00, opclear +0x08, intrEn +0x18, operand +0x20, result_h +0x28, result_l +0x30.
REQ-017 FSM states SHALL be: IDLE, REQ, RD_OP_A, RD_OP_D, WR_OPND, WR_IEN, WR_GO, WAIT_INT, RD_H_A, RD_H_D, RD_L_A, RD_L_D, WR_RH, WR_RL, WR_CLR, NEXT, FIN.
REQ-018 IDLE: on start=1, latch src_addr, dst_addr, count; clear idx; set busy; go to REQ, or to FIN if count=0.
REQ-019 Range check at acceptance: if src+8*count-1 > MEM_TOP or dst+16*count-1 > MEM_TOP, set err and go to FIN with no bus access.
REQ-020 REQ: assert m_req; advance to RD_OP_A the cycle after m_grant=1; m_req stays high for the whole batch.
REQ-021 Each bus-access state SHALL present m_addr/m_wr/m_dout for exactly one cycle while m_grant=1; if m_grant=0, the FSM holds state and outputs unchanged.
REQ-022 Reads: address phase (RD_*_A, m_wr=0); m_din captured in the following RD_*_D cycle (one-cycle read latency).
REQ-023 Per operand i: read mem[src+8i]; write operand; write intrEn=1; write opstart=1; WAIT_INT until interrupt=1; read result_h, result_l; write mem[dst+16i]=result_h and mem[dst+16i+8]=result_l; write opclear=1; then NEXT.
REQ-024 Write data for intrEn, opstart, opclear SHALL be 64'd1.
REQ-025 NEXT: idx+1; if idx+1 = count go to FIN, else go to RD_OP_A.
REQ-026 Outside bus-access states, m_wr=0 and m_addr/m_dout hold their last value.
REQ-027 FIN: deassert m_req, pulse done for one cycle, clear busy, return to IDLE next cycle.
REQ-028 start asserted while busy SHALL be ignored; a spurious interrupt outside WAIT_INT SHALL be ignored.
REQ-029 Batch latency with m_grant held high and interrupt arriving K cycles after opstart: 2 + count*(13+K) + 1 cycles from start to done.

Reset
REQ-030 reset_n=0 at any time SHALL force IDLE with m_req=0, m_wr=0, m_addr=0, m_dout=0, busy=0, done=0, err=0, idx=0; an interrupted batch is abandoned without issuing opclear.

Verification
REQ-031 Single operand: mem[0x0000]=5, src=0x0000, dst=0x0100, count=1 -> mem[0x0100]=0, mem[0x0108]=120, one done pulse, opclear written once.
REQ-032 Batch: operands 0,1,3,10 at 0x0000..0x0018, count=4 -> results 1,1,6,3628800 in result_l at 0x0108/0x0118/0x0128/0x0138; busy high throughout.
REQ-033 Grant stall: drop m_grant for 5 cycles during WR_GO -> m_addr=0x7000 and m_wr=1 held; the write completes once after regrant; results are unchanged.
REQ-034 Edge cases: count=0 -> done 1 cycle after start with no m_req; dst=0x07F8, count=1 -> err=1, no bus activity.
REQ-035 Reset mid-batch: deassert reset_n during WAIT_INT -> all outputs zero at once; a new start afterwards runs the batch correctly.
REQ-036 Start while busy: pulse start in WAIT_INT -> ignored; exactly one done pulse for the batch.
